// File: rtl/spi_cmd_scheduler_if.sv
// Command FIFO, result FIFO and byte-engine signals seen by spi_cmd_scheduler.
// master = scheduler side, slave = FIFOs/engine side.
interface spi_cmd_scheduler_if;
  localparam int unsigned CMD_W  = 17;
  localparam int unsigned BYTE_W = 8;

  logic              cmd_empty;
  logic              cmd_rd_en;
  logic [CMD_W-1:0]  cmd_dout;
  logic              res_full;
  logic              res_wr_en;
  logic [BYTE_W-1:0] res_din;
  logic              eng_write_start;
  logic              eng_read_start;
  logic              eng_config;
  logic [BYTE_W-1:0] eng_addr;
  logic [BYTE_W-1:0] eng_data;
  logic              eng_w_finish;
  logic              eng_rd_valid;
  logic [BYTE_W-1:0] eng_rd_data;

  modport master (
    input  cmd_empty, cmd_dout, res_full, eng_w_finish, eng_rd_valid, eng_rd_data,
    output cmd_rd_en, res_wr_en, res_din, eng_write_start, eng_read_start,
           eng_config, eng_addr, eng_data
  );

  modport slave (
    output cmd_empty, cmd_dout, res_full, eng_w_finish, eng_rd_valid, eng_rd_data,
    input  cmd_rd_en, res_wr_en, res_din, eng_write_start, eng_read_start,
           eng_config, eng_addr, eng_data
  );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Configures the SPI byte engine after reset / on request, then drains the command
// FIFO one single-byte transaction at a time with a watchdog on completion.
module spi_cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned CFG_WAIT_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       itf_sel,
  input  logic                       cfg_req,
  input  logic                       clr_err,
  spi_cmd_scheduler_if.master        bus,
  output logic                       busy,
  output logic                       cfg_done,
  output logic                       timeout_err
);

  localparam int unsigned RW_BIT = 16;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CFG_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    CFG_ISSUE,
    CFG_WAIT,
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    PUSH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rw;
  logic             cfg_pend;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state               <= CFG_ISSUE;
      cnt                 <= '0;
      rw                  <= 1'b0;
      cfg_pend            <= 1'b0;
      bus.cmd_rd_en       <= 1'b0;
      bus.res_wr_en       <= 1'b0;
      bus.res_din         <= '0;
      bus.eng_write_start <= 1'b0;
      bus.eng_read_start  <= 1'b0;
      bus.eng_config      <= 1'b0;
      bus.eng_addr        <= '0;
      bus.eng_data        <= '0;
      busy                <= 1'b0;
      cfg_done            <= 1'b0;
      timeout_err         <= 1'b0;
    end else begin
      bus.cmd_rd_en       <= 1'b0;
      bus.res_wr_en       <= 1'b0;
      bus.eng_write_start <= 1'b0;
      bus.eng_read_start  <= 1'b0;
      bus.eng_config      <= 1'b0;
      if (cfg_req) cfg_pend <= 1'b1;
      // A timeout later in this block overrides a simultaneous clear.
      if (clr_err) timeout_err <= 1'b0;

      case (state)
        // Pulse is raised inside CFG_ISSUE and the state is left on the following edge.
        CFG_ISSUE: begin
          busy <= 1'b1;
          if (bus.eng_config) begin
            state <= CFG_WAIT;
            cnt   <= '0;
          end else if (itf_sel) begin
            bus.eng_config <= 1'b1;
          end
        end
        CFG_WAIT: begin
          if (cnt == CFG_LAST) begin
            state    <= IDLE;
            cfg_done <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE: begin
          if (cfg_pend || cfg_req) begin
            state    <= CFG_ISSUE;
            cfg_pend <= 1'b0;
            busy     <= 1'b1;
          end else if (itf_sel && !bus.cmd_empty) begin
            state         <= FETCH;
            bus.cmd_rd_en <= 1'b1;
            busy          <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          rw                  <= bus.cmd_dout[RW_BIT];
          bus.eng_addr        <= bus.cmd_dout[15:8];
          bus.eng_data        <= bus.cmd_dout[7:0];
          bus.eng_write_start <= ~bus.cmd_dout[RW_BIT];
          bus.eng_read_start  <= bus.cmd_dout[RW_BIT];
          state               <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        // Completion flags are tested before the watchdog so a same-cycle flag wins.
        WAIT_DONE: begin
          if (!rw && bus.eng_w_finish) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rw && bus.eng_rd_valid) begin
            bus.res_din   <= bus.eng_rd_data;
            bus.res_wr_en <= ~bus.res_full;
            state         <= PUSH;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PUSH: begin
          if (bus.res_wr_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!bus.res_full) begin
            bus.res_wr_en <= 1'b1;
          end
        end
        default: state <= CFG_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: FIFO and byte-engine models plus
// per-scenario tasks with hand-computed cycle expectations.
module tb_spi_cmd_scheduler;
  localparam int unsigned T_TO = 64;
  localparam int unsigned T_CW = 4;

  logic CLK = 1'b0;
  logic rst_n, itf_sel, cfg_req, clr_err;
  logic busy, cfg_done, timeout_err;

  spi_cmd_scheduler_if bus();

  spi_cmd_scheduler #(
    .TIMEOUT_CYCLES (T_TO),
    .CFG_WAIT_CYCLES(T_CW),
    .CNT_W          (16)
  ) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .itf_sel    (itf_sel),
    .cfg_req    (cfg_req),
    .clr_err    (clr_err),
    .bus        (bus),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Command FIFO model: data appears the cycle after the read strobe.
  logic [16:0] mem [0:15];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;
  assign bus.cmd_empty = (wr_ptr == rd_ptr);
  always @(posedge CLK) begin
    if (bus.cmd_rd_en) begin
      bus.cmd_dout <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 4'd1;
    end
  end

  task automatic push_cmd(input logic [16:0] c);
    mem[wr_ptr] = c;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Byte-engine model: flag visible eng_delay cycles after the start pulse.
  logic       resp_en = 1'b1;
  int         eng_delay = 3;
  logic [7:0] rd_byte = 8'h00;
  logic       e_busy = 1'b0;
  logic       e_rd = 1'b0;
  int         e_cnt = 0;
  always @(posedge CLK) begin
    bus.eng_w_finish <= 1'b0;
    bus.eng_rd_valid <= 1'b0;
    if (!rst_n) begin
      e_busy <= 1'b0;
    end else begin
      if (e_busy) begin
        if (e_cnt == 1) begin
          e_busy <= 1'b0;
          if (e_rd) begin
            bus.eng_rd_valid <= 1'b1;
            bus.eng_rd_data  <= rd_byte;
          end else begin
            bus.eng_w_finish <= 1'b1;
          end
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
      if (resp_en && (bus.eng_write_start || bus.eng_read_start)) begin
        e_busy <= 1'b1;
        e_rd   <= bus.eng_read_start;
        e_cnt  <= eng_delay - 1;
      end
    end
  end

  // Event monitor sampled on the falling edge.
  int n_rd = 0, n_ws = 0, n_rs = 0, n_cfg = 0, n_res = 0, n_rv = 0, strobe_viol = 0;
  int rd_cyc = 0, ws_cyc = 0, rs_cyc = 0, cfg_cyc = 0, res_cyc = 0, rv_cyc = 0;
  int idle_cyc = 0, cfg_done_cyc = 0, err_cyc = 0;
  logic [7:0] res_val = 8'h00;
  logic rd_prev_idle = 1'b0, p_busy = 1'b0, p_cfg_done = 1'b0, p_err = 1'b0;
  always @(negedge CLK) begin
    if (bus.cmd_rd_en) begin n_rd++; rd_cyc = cyc; rd_prev_idle = !p_busy; end
    if (bus.eng_write_start) begin n_ws++; ws_cyc = cyc; end
    if (bus.eng_read_start) begin n_rs++; rs_cyc = cyc; end
    if (bus.eng_config) begin n_cfg++; cfg_cyc = cyc; end
    if (bus.res_wr_en) begin n_res++; res_cyc = cyc; res_val = bus.res_din; end
    if (bus.eng_rd_valid) begin n_rv++; rv_cyc = cyc; end
    if (32'(bus.eng_write_start) + 32'(bus.eng_read_start) + 32'(bus.eng_config) > 1) strobe_viol++;
    if (p_busy && !busy) idle_cyc = cyc;
    if (cfg_done && !p_cfg_done) cfg_done_cyc = cyc;
    if (timeout_err && !p_err) err_cyc = cyc;
    p_busy = busy;
    p_cfg_done = cfg_done;
    p_err = timeout_err;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.cmd_rd_en, bus.res_wr_en, bus.res_din, bus.eng_write_start, bus.eng_read_start,
            bus.eng_config, bus.eng_addr, bus.eng_data, busy, cfg_done, timeout_err};
  endfunction

  task automatic wait_idle(input int lim, input string name);
    int i;
    i = 0;
    step();
    while (!(busy == 1'b0 && cfg_done == 1'b1) && i < lim) begin step(); i++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle wait: busy=%b required 0", name, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; itf_sel = 1'b1; cfg_req = 1'b0; clr_err = 1'b0; bus.res_full = 1'b0;
    resp_en = 1'b1; eng_delay = 3;
    push_cmd({1'b0, 8'h33, 8'h11});
    repeat (3) step();
    checks++;
    if (all_outs() !== 32'h0) begin errors++; $display("FAIL reset outs: got %h required 0", all_outs()); end
    rst_n = 1'b1;
    for (int i = 0; i < 20 && n_cfg == 0; i++) step();
    for (int i = 0; i < 20 && !cfg_done; i++) step();
    checks++;
    if (n_cfg !== 1) begin errors++; $display("FAIL reset cfg pulses: got %0d required 1", n_cfg); end
    checks++;
    if (cfg_done_cyc !== cfg_cyc + 5) begin errors++; $display("FAIL reset cfg_done delay: got %0d required %0d", cfg_done_cyc - cfg_cyc, 5); end
    checks++;
    if (n_rd !== 0) begin errors++; $display("FAIL reset early fetch: got %0d required 0", n_rd); end
    for (int i = 0; i < 10 && n_rd == 0; i++) step();
    checks++;
    if (rd_cyc !== cfg_done_cyc + 1) begin errors++; $display("FAIL reset first fetch cycle: got %0d required %0d", rd_cyc, cfg_done_cyc + 1); end
    wait_idle(50, "reset");
  endtask

  task automatic test_write();
    int rd0, ws0, res0;
    rd0 = n_rd; ws0 = n_ws; res0 = n_res;
    eng_delay = 10;
    push_cmd({1'b0, 8'h12, 8'hA5});
    for (int i = 0; i < 20 && n_ws == ws0; i++) step();
    wait_idle(50, "write");
    checks++;
    if (n_rd - rd0 !== 1) begin errors++; $display("FAIL write fetches: got %0d required 1", n_rd - rd0); end
    checks++;
    if ({bus.eng_addr, bus.eng_data} !== 16'h12A5) begin errors++; $display("FAIL write addr/data: got %h required 12a5", {bus.eng_addr, bus.eng_data}); end
    checks++;
    if (n_ws - ws0 !== 1) begin errors++; $display("FAIL write starts: got %0d required 1", n_ws - ws0); end
    checks++;
    if (!rd_prev_idle || ws_cyc !== rd_cyc + 2) begin errors++; $display("FAIL write start latency: got %0d idle %b required 3", ws_cyc - rd_cyc + 1, rd_prev_idle); end
    checks++;
    if (idle_cyc !== ws_cyc + 11) begin errors++; $display("FAIL write idle cycle: got %0d required %0d", idle_cyc, ws_cyc + 11); end
    checks++;
    if (n_res !== res0) begin errors++; $display("FAIL write result push: got %0d required %0d", n_res, res0); end
  endtask

  task automatic test_read_full();
    int rv0, res0, f;
    rv0 = n_rv; res0 = n_res;
    eng_delay = 4; rd_byte = 8'h5C; bus.res_full = 1'b1;
    push_cmd({1'b1, 8'h40, 8'h00});
    for (int i = 0; i < 30 && n_rv == rv0; i++) step();
    repeat (5) step();
    checks++;
    if (bus.res_din !== 8'h5C || n_res !== res0) begin errors++; $display("FAIL read hold: din=%h pushes=%0d required 5c/%0d", bus.res_din, n_res - res0, 0); end
    bus.res_full = 1'b0;
    f = cyc;
    repeat (2) step();
    checks++;
    if (n_res - res0 !== 1) begin errors++; $display("FAIL read pushes: got %0d required 1", n_res - res0); end
    checks++;
    if (res_cyc !== f + 1 || res_val !== 8'h5C) begin errors++; $display("FAIL read push timing: cyc=%0d val=%h required %0d/5c", res_cyc, res_val, f + 1); end
    wait_idle(20, "read");
  endtask

  task automatic test_timeout();
    int rs0, ws0, res0, ec;
    rs0 = n_rs; res0 = n_res;
    resp_en = 1'b0;
    push_cmd({1'b1, 8'h07, 8'h00});
    for (int i = 0; i < 20 && n_rs == rs0; i++) step();
    for (int i = 0; i < int'(T_TO) + 20 && !timeout_err; i++) step();
    checks++;
    if (!timeout_err || err_cyc !== rs_cyc + int'(T_TO) + 1) begin errors++; $display("FAIL timeout rise: err=%b cyc=%0d required 1/%0d", timeout_err, err_cyc, rs_cyc + int'(T_TO) + 1); end
    wait_idle(10, "timeout");
    checks++;
    if (n_res !== res0) begin errors++; $display("FAIL timeout push: got %0d required %0d", n_res - res0, 0); end
    resp_en = 1'b1; eng_delay = 3; ws0 = n_ws; ec = err_cyc;
    push_cmd({1'b0, 8'h21, 8'h3C});
    for (int i = 0; i < 20 && n_ws == ws0; i++) step();
    wait_idle(20, "post-timeout");
    checks++;
    if (n_ws - ws0 !== 1 || bus.eng_addr !== 8'h21 || !timeout_err) begin errors++; $display("FAIL post-timeout write: starts=%0d addr=%h err=%b required 1/21/1", n_ws - ws0, bus.eng_addr, timeout_err); end
    clr_err = 1'b1; step(); clr_err = 1'b0; step();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b required 0", timeout_err); end
    // Second timeout with clr_err landing in the timeout cycle.
    resp_en = 1'b0; rs0 = n_rs;
    push_cmd({1'b1, 8'h08, 8'h00});
    for (int i = 0; i < 20 && n_rs == rs0; i++) step();
    repeat (T_TO) step();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || err_cyc == ec) begin errors++; $display("FAIL clr vs timeout: got %b required 1", timeout_err); end
    wait_idle(10, "timeout2");
    clr_err = 1'b1; step(); clr_err = 1'b0; step();
    resp_en = 1'b1;
  endtask

  task automatic test_flag_at_timeout();
    int res0, rv0;
    res0 = n_res; rv0 = n_rv;
    eng_delay = int'(T_TO); rd_byte = 8'h9E;
    push_cmd({1'b1, 8'h09, 8'h00});
    for (int i = 0; i < int'(T_TO) + 30 && n_rv == rv0; i++) step();
    wait_idle(10, "edge");
    checks++;
    if (rv_cyc !== rs_cyc + int'(T_TO)) begin errors++; $display("FAIL edge flag cycle: got %0d required %0d", rv_cyc, rs_cyc + int'(T_TO)); end
    checks++;
    if (timeout_err !== 1'b0 || n_res - res0 !== 1 || res_val !== 8'h9E) begin errors++; $display("FAIL edge flag wins: err=%b pushes=%0d val=%h required 0/1/9e", timeout_err, n_res - res0, res_val); end
  endtask

  task automatic test_itf_sel();
    int rd0;
    rd0 = n_rd; eng_delay = 3; itf_sel = 1'b0;
    push_cmd({1'b0, 8'h44, 8'h55});
    repeat (10) step();
    checks++;
    if (n_rd !== rd0) begin errors++; $display("FAIL itf_sel gate: got %0d fetches required 0", n_rd - rd0); end
    itf_sel = 1'b1;
    for (int i = 0; i < 10 && n_rd == rd0; i++) step();
    wait_idle(20, "itf_sel");
    checks++;
    if ({bus.eng_addr, bus.eng_data} !== 16'h4455) begin errors++; $display("FAIL itf_sel resume: got %h required 4455", {bus.eng_addr, bus.eng_data}); end
  endtask

  task automatic test_cfg_req();
    int rd0, ws0, cfg0, w1;
    rd0 = n_rd; ws0 = n_ws; cfg0 = n_cfg; eng_delay = 8;
    push_cmd({1'b0, 8'h50, 8'h01});
    push_cmd({1'b0, 8'h51, 8'h02});
    push_cmd({1'b0, 8'h52, 8'h03});
    for (int i = 0; i < 20 && n_ws == ws0; i++) step();
    w1 = ws_cyc;
    step(); cfg_req = 1'b1; step(); cfg_req = 1'b0; step(); cfg_req = 1'b1; step(); cfg_req = 1'b0;
    for (int i = 0; i < 40 && n_cfg == cfg0; i++) step();
    checks++;
    if (cfg_cyc !== w1 + 11 || n_rd - rd0 !== 1) begin errors++; $display("FAIL cfg_req service: cyc=%0d fetches=%0d required %0d/1", cfg_cyc, n_rd - rd0, w1 + 11); end
    for (int i = 0; i < 200 && n_ws - ws0 < 3; i++) step();
    wait_idle(40, "cfg_req");
    checks++;
    if (n_cfg - cfg0 !== 1) begin errors++; $display("FAIL cfg_req collapse: got %0d required 1", n_cfg - cfg0); end
    checks++;
    if (n_rd - rd0 !== 3 || {bus.eng_addr, bus.eng_data} !== 16'h5203 || !cfg_done) begin errors++; $display("FAIL cfg_req resume: fetches=%0d ad=%h required 3/5203", n_rd - rd0, {bus.eng_addr, bus.eng_data}); end
  endtask

  task automatic test_reset_mid();
    int rs0, cfg0, rd0;
    rs0 = n_rs; resp_en = 1'b0;
    push_cmd({1'b1, 8'h66, 8'h00});
    for (int i = 0; i < 20 && n_rs == rs0; i++) step();
    repeat (3) step();
    rst_n = 1'b0; step();
    checks++;
    if (all_outs() !== 32'h0) begin errors++; $display("FAIL mid reset outs: got %h required 0", all_outs()); end
    cfg0 = n_cfg; rd0 = n_rd;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && n_cfg == cfg0; i++) step();
    checks++;
    if (n_cfg - cfg0 !== 1 || cfg_done !== 1'b0) begin errors++; $display("FAIL mid reset reconfig: pulses=%0d done=%b required 1/0", n_cfg - cfg0, cfg_done); end
    for (int i = 0; i < 20 && !cfg_done; i++) step();
    repeat (3) step();
    checks++;
    if (cfg_done_cyc !== cfg_cyc + 5 || n_rd !== rd0 || busy !== 1'b0) begin errors++; $display("FAIL mid reset cfg_done: delay=%0d fetches=%0d required 5/0", cfg_done_cyc - cfg_cyc, n_rd - rd0); end
    resp_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_full();
    test_timeout();
    test_flag_at_timeout();
    test_itf_sel();
    test_cfg_req();
    test_reset_mid();
    checks++;
    if (strobe_viol !== 0) begin errors++; $display("FAIL strobe overlap: got %0d required 0", strobe_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
